// File: rtl/line_buffer_ctrl_if.sv
// Pixel stream, line buffer and window-output bundle of line_buffer_ctrl.
// Signal names keep the controller's point of view (i_ = into the controller).
interface line_buffer_ctrl_if;
    logic [7:0]  i_pixel_data;
    logic        i_pixel_data_valid;
    logic [7:0]  o_lb_data;
    logic [3:0]  o_lb_wr_valid;
    logic [23:0] i_lb0_data;
    logic [23:0] i_lb1_data;
    logic [23:0] i_lb2_data;
    logic [23:0] i_lb3_data;
    logic [3:0]  o_lb_rd;
    logic [71:0] o_pixel_data;
    logic        o_pixel_data_valid;
    logic        o_intr;

    // Controller side.
    modport slave (
        input  i_pixel_data, i_pixel_data_valid,
        input  i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data,
        output o_lb_data, o_lb_wr_valid, o_lb_rd,
        output o_pixel_data, o_pixel_data_valid, o_intr
    );

    // Host / line buffer / convolution side.
    modport master (
        output i_pixel_data, i_pixel_data_valid,
        output i_lb0_data, i_lb1_data, i_lb2_data, i_lb3_data,
        input  o_lb_data, o_lb_wr_valid, o_lb_rd,
        input  o_pixel_data, o_pixel_data_valid, o_intr
    );
endinterface

// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl: steers the pixel stream into four line buffers in rotation,
// tracks buffered-pixel occupancy, and once three lines are held reads three
// adjacent buffers in lockstep to emit one 3x3 window per cycle.
module line_buffer_ctrl #(
    parameter int IMG_WIDTH = 512
) (
    input  logic              i_clk,
    input  logic              i_rst,
    line_buffer_ctrl_if.slave lb_if
);

    localparam logic [8:0]  LAST_COL  = 9'(IMG_WIDTH - 1);
    localparam logic [11:0] READ_THR  = 12'(3 * IMG_WIDTH);

    typedef enum logic {
        S_IDLE,
        S_READ
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [8:0]  r_wr_cnt;
    logic [1:0]  r_wr_sel;
    logic [8:0]  r_rd_cnt;
    logic [1:0]  r_rd_sel;
    logic [11:0] r_occ;
    logic        r_intr;

    logic        w_wr;
    logic        w_rd;
    logic        w_line_done;
    logic        w_out_valid;
    logic [1:0]  w_mid;
    logic [1:0]  w_bot;
    logic [3:0]  w_rd_mask;
    logic [71:0] w_window;
    logic [23:0] w_lb [4];

    assign w_wr        = lb_if.i_pixel_data_valid;
    assign w_rd        = (r_state == S_READ);
    assign w_line_done = w_rd && (r_rd_cnt == LAST_COL);
    assign w_mid       = r_rd_sel + 2'd1;
    assign w_bot       = r_rd_sel + 2'd2;

    assign w_lb[0] = lb_if.i_lb0_data;
    assign w_lb[1] = lb_if.i_lb1_data;
    assign w_lb[2] = lb_if.i_lb2_data;
    assign w_lb[3] = lb_if.i_lb3_data;

    // Write-side position: column within the line and target buffer.
    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (i_rst) begin
            r_wr_cnt <= '0;
            r_wr_sel <= '0;
        end else if (w_wr) begin
            if (r_wr_cnt == LAST_COL) begin
                r_wr_cnt <= '0;
                r_wr_sel <= r_wr_sel + 2'd1;
            end else begin
                r_wr_cnt <= r_wr_cnt + 9'd1;
            end
        end
    end

    // Occupancy: a write and a read in the same cycle cancel out.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_occ <= '0;
        end else begin
            case ({w_wr, w_rd})
                2'b10:   r_occ <= r_occ + 12'd1;
                2'b01:   r_occ <= r_occ - 12'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and window-valid output.
    always_comb begin
        // NOTE: defaults first so no path through the case leaves a variable
        // unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_out_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_occ >= READ_THR) begin
                    w_state_nxt = S_READ;
                end
            end
            S_READ: begin
                w_out_valid = 1'b1;
                if (r_rd_cnt == LAST_COL) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Read-side position: column within the output line and top buffer.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rd_cnt <= '0;
            r_rd_sel <= '0;
        end else if (w_rd) begin
            if (r_rd_cnt == LAST_COL) begin
                r_rd_cnt <= '0;
                r_rd_sel <= r_rd_sel + 2'd1;
            end else begin
                r_rd_cnt <= r_rd_cnt + 9'd1;
            end
        end
    end

    // Line-consumed interrupt, high in the IDLE cycle after each line.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_intr <= 1'b0;
        end else begin
            r_intr <= w_line_done;
        end
    end

    // Window assembly and read-pointer steering for the three active buffers.
    always_comb begin
        w_window  = {w_lb[r_rd_sel], w_lb[w_mid], w_lb[w_bot]};
        w_rd_mask = '0;
        if (w_rd) begin
            w_rd_mask = (4'b0001 << r_rd_sel) | (4'b0001 << w_mid) | (4'b0001 << w_bot);
        end
    end

    assign lb_if.o_lb_data          = lb_if.i_pixel_data;
    assign lb_if.o_lb_wr_valid      = w_wr ? (4'b0001 << r_wr_sel) : 4'b0000;
    assign lb_if.o_lb_rd            = w_rd_mask;
    assign lb_if.o_pixel_data       = w_window;
    assign lb_if.o_pixel_data_valid = w_out_valid;
    assign lb_if.o_intr             = r_intr;

endmodule

// File: tb/tb_line_buffer_ctrl.sv
// Self-checking bench for line_buffer_ctrl: models the four line buffers as the
// environment and predicts outputs from the image lines written so far.
module tb_line_buffer_ctrl;

    localparam int W = 512;

    logic clk;
    logic rst;

    line_buffer_ctrl_if lb_if ();

    line_buffer_ctrl #(.IMG_WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .lb_if (lb_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Environment: four line buffers with their own write/read pointers.
    logic [7:0] env_mem [4][W];
    int         env_wp [4];
    int         env_rp [4];

    // Reference image: every pixel written since reset, by line and column.
    logic [7:0] img [16][W];
    int  m_written;   // pixels accepted since reset
    int  m_occ;       // pixels buffered, as visible this cycle
    bit  m_reading;   // window stream active this cycle
    int  m_col;       // column of current output window
    int  m_line;      // index of current / next output line (top row)
    bit  m_intr;
    int  cyc;
    int  last_wr_cyc;
    int  first_valid_cyc;

    function automatic logic [23:0] env_win(input int b);
        int r;
        r = env_rp[b];
        return {env_mem[b][r], env_mem[b][(r + 1) % W], env_mem[b][(r + 2) % W]};
    endfunction

    function automatic logic [71:0] exp_window(input int k, input int c);
        logic [71:0] w;
        w = '0;
        for (int r = 0; r < 3; r++) begin
            for (int j = 0; j < 3; j++) begin
                w = {w[63:0], img[k + r][(c + j) % W]};
            end
        end
        return w;
    endfunction

    function automatic logic [3:0] exp_mask(input int k);
        logic [3:0] m;
        m = 4'b0000;
        for (int r = 0; r < 3; r++) m[(k + r) % 4] = 1'b1;
        return m;
    endfunction

    task automatic drive_lb();
        lb_if.i_lb0_data = env_win(0);
        lb_if.i_lb1_data = env_win(1);
        lb_if.i_lb2_data = env_win(2);
        lb_if.i_lb3_data = env_win(3);
    endtask

    // One clock cycle: drive, check at negedge, advance environment and model.
    task automatic step(input logic rst_in, input logic v, input logic [7:0] d);
        logic [3:0] s_wr;
        logic [3:0] s_rd;
        logic [3:0] exp_wr;
        rst = rst_in;
        lb_if.i_pixel_data_valid = v;
        lb_if.i_pixel_data = d;
        @(negedge clk);
        exp_wr = v ? 4'(1 << ((m_written / W) % 4)) : 4'b0000;
        check("lb_data", 72'(lb_if.o_lb_data), 72'(d));
        check("wr_valid", 72'(lb_if.o_lb_wr_valid), 72'(exp_wr));
        check("out_valid", 72'(lb_if.o_pixel_data_valid), 72'(m_reading));
        check("intr", 72'(lb_if.o_intr), 72'(m_intr));
        check("lb_rd", 72'(lb_if.o_lb_rd), 72'(m_reading ? exp_mask(m_line) : 4'b0000));
        if (m_reading) begin
            check("window", lb_if.o_pixel_data, exp_window(m_line, m_col));
            if (first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        s_wr = lb_if.o_lb_wr_valid;
        s_rd = lb_if.o_lb_rd;
        @(posedge clk);
        #1;
        cyc++;
        if (rst_in) begin
            for (int b = 0; b < 4; b++) begin
                env_wp[b] = 0;
                env_rp[b] = 0;
            end
            m_written = 0;
            m_occ     = 0;
            m_reading = 1'b0;
            m_col     = 0;
            m_line    = 0;
            m_intr    = 1'b0;
        end else begin
            for (int b = 0; b < 4; b++) begin
                if (s_wr[b]) begin
                    env_mem[b][env_wp[b]] = d;
                    env_wp[b] = (env_wp[b] + 1) % W;
                end
                if (s_rd[b]) env_rp[b] = (env_rp[b] + 1) % W;
            end
            m_intr = m_reading && (m_col == W - 1);
            m_occ  = m_occ + (v ? 1 : 0) - (m_reading ? 1 : 0);
            if (m_reading) begin
                m_col++;
                if (m_col == W) begin
                    m_reading = 1'b0;
                    m_col     = 0;
                    m_line++;
                end
            end else if (m_occ - (v ? 1 : 0) >= 3 * W) begin
                m_reading = 1'b1;
            end
            if (v) begin
                img[m_written / W][m_written % W] = d;
                m_written++;
                if (m_written == 3 * W) last_wr_cyc = cyc - 1;
            end
        end
        drive_lb();
    endtask

    initial begin
        logic       v;
        logic [7:0] d;
        rst = 1'b1;
        lb_if.i_pixel_data_valid = 1'b0;
        lb_if.i_pixel_data = 8'h00;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < W; i++) env_mem[b][i] = 8'h00;
        end
        cyc = 0;
        last_wr_cyc = -1;
        first_valid_cyc = -1;
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);

        // Part of a line, then a 2-cycle reset mid-stream.
        for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 8'($urandom));
        step(1'b1, 1'b0, 8'h00);
        step(1'b1, 1'b0, 8'h00);
        check("rst_out_valid", 72'(lb_if.o_pixel_data_valid), 72'(0));
        check("rst_lb_rd", 72'(lb_if.o_lb_rd), 72'(0));
        check("rst_intr", 72'(lb_if.o_intr), 72'(0));
        last_wr_cyc = -1;
        first_valid_cyc = -1;

        // Main run: ten lines, host never gets more than four lines ahead.
        while (m_line < 8 && cyc < 30000) begin
            v = ($urandom_range(0, 3) != 0) && (m_written < 10 * W)
                && (m_written < W * (4 + m_line));
            if (m_written < 3 * W)
                d = 8'(((m_written / W) * 16) + ((m_written % W) % 16));
            else
                d = 8'($urandom);
            if (m_reading && m_line == 0 && m_col == 0) begin
                check("first_window", exp_window(0, 0), 72'h000102_101112_202122);
            end
            step(1'b0, v, d);
        end
        check("lines_done", 72'(m_line), 72'(8));
        check("read_start_lat", 72'(first_valid_cyc - last_wr_cyc), 72'(2));
        for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Control stage directly upstream of the four 512-entry line buffers in the 3x3 spatial filter datapath. Steers the incoming 8-bit pixel stream into one of four line buffers in rotation and tracks buffered-pixel occupancy. Once three full lines are held, it reads three adjacent buffers in lockstep and emits one 72-bit 3x3 window per cycle to the convolution stage. After each consumed line it pulses an interrupt so the host/DMA sends the next line.

## Interface
- IMG_WIDTH, 512, pixels per line; must equal line buffer depth (512).
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_pixel_data  in  8  incoming pixel.
- i_pixel_data_valid  in  1  qualifies i_pixel_data; no backpressure.
- o_lb_data  out  8  pixel to line buffers; equals i_pixel_data (combinational).
- o_lb_wr_valid  out  4  one-hot per-buffer write enable.
- i_lb0_data..i_lb3_data  in  24 each  3-pixel window from buffer n, {p[r], p[r+1], p[r+2]}.
- o_lb_rd  out  4  per-buffer read-pointer advance.
- o_pixel_data  out  72  3x3 window {top 24, middle 24, bottom 24}.
- o_pixel_data_valid  out  1  qualifies o_pixel_data.
- o_intr  out  1  one-cycle pulse: one line consumed.

## Operation
- Write side: wr_cnt (9b) counts accepted pixels 0..IMG_WIDTH-1. wr_sel (2b) increments mod 4 when a valid pixel is accepted with wr_cnt == IMG_WIDTH-1. o_lb_wr_valid = i_pixel_data_valid ? (1 << wr_sel) : 0.
- Occupancy: occ (12b). Write only: +1. Read only: -1. Both in the same cycle: unchanged. Neither: unchanged.
- FSM, two states:
  - IDLE: o_pixel_data_valid = 0. Go to READ when occ >= 3*IMG_WIDTH (1536).
  - READ: o_pixel_data_valid = 1. rd_cnt (9b) counts 0..IMG_WIDTH-1. On rd_cnt == IMG_WIDTH-1: return to IDLE, rd_cnt -> 0, rd_sel increments mod 4.
- Read steering: top = buffer rd_sel, middle = rd_sel+1, bottom = rd_sel+2 (all mod 4).
  - o_pixel_data = {i_lb[top], i_lb[mid], i_lb[bot]}, combinational mux on rd_sel.
  - o_lb_rd has those three bits set while in READ, otherwise 0.
- o_intr: registered; set for exactly one cycle after the READ->IDLE transition.
- Edge windows: the last two windows of each line include pixels wrapped from the start of the same buffer. They are emitted as-is; the downstream stage discards them.
- Overflow: occupancy above 4*IMG_WIDTH is a host protocol violation. It is not detected; the host sends at most one line per o_intr after the initial four.
- Reset: all counters, wr_sel, rd_sel, occ, FSM (IDLE), o_intr and o_pixel_data_valid -> 0. Reset mid-READ aborts the line with no o_intr. Line buffer contents are don't-care after reset.

## Timing
- Write path: zero latency; o_lb_wr_valid and o_lb_data follow the inputs in the same cycle.
- Read start:
  - Cycle N: the 1536th write is accepted; occ becomes 1536 at edge N+1.
  - Cycle N+1: FSM sees occ >= 1536 in IDLE and registers READ at edge N+2.
  - o_pixel_data_valid is high from cycle N+2 for exactly IMG_WIDTH consecutive cycles.
- Window alignment: o_pixel_data is valid in the same cycle as o_pixel_data_valid (line buffer output is combinational). The read pointers advance at the end of each valid cycle.
- Line end: FSM spends at least one cycle in IDLE after every line, even if occ >= 1536 still holds. o_intr is high in that IDLE cycle.
- Back-to-back lines: minimum period is IMG_WIDTH+1 cycles per output line.

## Test plan
- Reset: assert i_rst 2 cycles mid-stream -> all outputs 0, FSM IDLE; next pixel goes to buffer 0 (o_lb_wr_valid = 4'b0001).
- Fill: stream 1536 pixels with valid, value = line index*16 + (col mod 16) -> o_lb_wr_valid walks 0001, 0010, 0100 at 512-pixel boundaries. o_pixel_data_valid rises 2 cycles after the 1536th pixel and stays high 512 cycles. o_lb_rd = 4'b0111.
- Window data: first window of line 0 = {00,01,02, 10,11,12, 20,21,22} hex bytes. Window at column 100 is checked against the model.
- Interrupt: o_intr high exactly 1 cycle, in the cycle after the last valid window; occ = 1024 afterwards.
- Concurrent write/read: stream line 3 into buffer 3 during the first READ -> occ is constant on overlapping cycles. The second READ starts after o_intr, uses rd_sel = 1 with o_lb_rd = 4'b1110, top rows from buffers 1, 2, 3.
- Wrap: stream 8 lines with prompt reads -> wr_sel and rd_sel wrap 3->0. Fifth read uses buffers {0, 1, 2} as {top, mid, bot}; sixth read uses buffers {1, 2, 3}, matching the model.
